// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine controller.
// Credit values are counted in half-units.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] HALF_VAL = 2'd1;
  localparam logic [1:0] ONE_VAL  = 2'd2;
  localparam int         SEL_W    = 3;

endpackage

// File: rtl/vend_change_disp.sv
// Change sequencer: picks the coin to return this cycle from the remaining amount.
// Returns 1-unit coins while possible, then a final 0.5-unit coin.
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic                start,
  input  logic [CREDIT_W-1:0] amount,
  output logic                change_one,
  output logic                change_half,
  output logic                done
);

  // Coin selection for the current change cycle
  always_comb begin
    change_one  = 1'b0;
    change_half = 1'b0;
    done        = 1'b0;
    if (start) begin
      if (amount >= CREDIT_W'(ONE_VAL)) begin
        change_one = 1'b1;
      end else if (amount != '0) begin
        change_half = 1'b1;
      end else begin
        done = 1'b1;
      end
    end else begin
      done = 1'b0;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Multi-product vending controller: credit register, purchase FSM and
// registered dispense/change/reject pulses.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                             N_ITEMS   = 2,
  parameter int                             CREDIT_W  = 4,
  parameter logic [N_ITEMS*CREDIT_W-1:0]    PRICES    = {4'd6, 4'd5},
  parameter int                             AUTO_VEND = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                half,
  input  logic                one,
  input  logic                buy,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                drink,
  output logic [SEL_W-1:0]    drink_id,
  output logic                change_one,
  output logic                change_half,
  output logic                coin_rej,
  output logic                buy_nak
);

  // Padded to eight entries so any sel value indexes safely.
  localparam logic [8*CREDIT_W-1:0] PRICE_TABLE = (8*CREDIT_W)'(PRICES);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                busy_q, busy_d;
  logic                drink_q, drink_d;
  logic [SEL_W-1:0]    drink_id_q, drink_id_d;
  logic                change_one_q, change_one_d;
  logic                change_half_q, change_half_d;
  logic                coin_rej_q, coin_rej_d;
  logic                buy_nak_q, buy_nak_d;

  logic [CREDIT_W-1:0] price_s, price0_s, dec_s;
  logic [1:0]          coin_val_s;
  logic [CREDIT_W:0]   sum_s;
  logic                sel_ok_s, coin_any_s, coin_ok_s, coin_bad_s;
  logic                disp_one_s, disp_half_s, disp_done_s;

  assign price_s    = PRICE_TABLE[int'(sel)*CREDIT_W +: CREDIT_W];
  assign price0_s   = PRICES[CREDIT_W-1:0];
  assign sel_ok_s   = ({1'b0, sel} < 4'(N_ITEMS));
  assign coin_any_s = half | one;
  assign coin_val_s = (half ? HALF_VAL : 2'd0) + (one ? ONE_VAL : 2'd0);
  assign sum_s      = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_val_s};
  assign coin_ok_s  = coin_any_s & ~sum_s[CREDIT_W];
  assign coin_bad_s = coin_any_s & sum_s[CREDIT_W];
  assign dec_s      = disp_one_s  ? CREDIT_W'(ONE_VAL)  :
                      disp_half_s ? CREDIT_W'(HALF_VAL) : '0;

  vend_change_disp #(
    .CREDIT_W (CREDIT_W)
  ) u_change_disp (
    .start       (state_q == CHANGE),
    .amount      (credit_q),
    .change_one  (disp_one_s),
    .change_half (disp_half_s),
    .done        (disp_done_s)
  );

  // Next-state, credit and output-pulse decode
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    drink_d       = 1'b0;
    drink_id_d    = '0;
    change_one_d  = 1'b0;
    change_half_d = 1'b0;
    coin_rej_d    = 1'b0;
    buy_nak_d     = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel && (credit_q != '0)) begin
          state_d    = CHANGE;
          coin_rej_d = coin_any_s;
        end else if (buy && sel_ok_s && (credit_q >= price_s)) begin
          state_d    = VEND;
          credit_d   = credit_q - price_s;
          drink_d    = 1'b1;
          drink_id_d = sel;
          coin_rej_d = coin_any_s;
        end else if ((AUTO_VEND != 0) && !buy && (state_q == COLLECT) &&
                     (credit_q >= price0_s)) begin
          state_d    = VEND;
          credit_d   = credit_q - price0_s;
          drink_d    = 1'b1;
          drink_id_d = '0;
          coin_rej_d = coin_any_s;
        end else begin
          // A refused buy still lets a coin in the same cycle through.
          buy_nak_d  = buy;
          credit_d   = coin_ok_s ? sum_s[CREDIT_W-1:0] : credit_q;
          state_d    = (coin_ok_s || (credit_q != '0)) ? COLLECT : IDLE;
          coin_rej_d = coin_bad_s;
        end
      end
      VEND: begin
        coin_rej_d = coin_any_s;
        state_d    = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_rej_d    = coin_any_s;
        change_one_d  = disp_one_s;
        change_half_d = disp_half_s;
        credit_d      = credit_q - dec_s;
        state_d       = disp_done_s ? IDLE : CHANGE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  // State, credit and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      busy_q        <= 1'b0;
      drink_q       <= 1'b0;
      drink_id_q    <= '0;
      change_one_q  <= 1'b0;
      change_half_q <= 1'b0;
      coin_rej_q    <= 1'b0;
      buy_nak_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      busy_q        <= busy_d;
      drink_q       <= drink_d;
      drink_id_q    <= drink_id_d;
      change_one_q  <= change_one_d;
      change_half_q <= change_half_d;
      coin_rej_q    <= coin_rej_d;
      buy_nak_q     <= buy_nak_d;
    end
  end

  assign credit      = credit_q;
  assign busy        = busy_q;
  assign drink       = drink_q;
  assign drink_id    = drink_id_q;
  assign change_one  = change_one_q;
  assign change_half = change_half_q;
  assign coin_rej    = coin_rej_q;
  assign buy_nak     = buy_nak_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: u_dut uses default parameters, u_auto has AUTO_VEND = 1.
// Both share stimulus; each scenario checks only the instance it targets.
module tb_vend_ctrl;
  logic       clk, rst, half, one, buy, cancel;
  logic [2:0] sel;
  logic [3:0] credit0, credit1;
  logic       busy0, drink0, chg_one0, chg_half0, rej0, nak0;
  logic       busy1, drink1, chg_one1, chg_half1, rej1, nak1;
  logic [2:0] id0, id1;
  int n_chk = 0;
  int n_fail = 0;

  vend_ctrl u_dut (
    .clk(clk), .rst(rst), .half(half), .one(one), .buy(buy), .sel(sel), .cancel(cancel),
    .credit(credit0), .busy(busy0), .drink(drink0), .drink_id(id0),
    .change_one(chg_one0), .change_half(chg_half0), .coin_rej(rej0), .buy_nak(nak0));

  vend_ctrl #(.AUTO_VEND(1)) u_auto (
    .clk(clk), .rst(rst), .half(half), .one(one), .buy(buy), .sel(sel), .cancel(cancel),
    .credit(credit1), .busy(busy1), .drink(drink1), .drink_id(id1),
    .change_one(chg_one1), .change_half(chg_half1), .coin_rej(rej1), .buy_nak(nak1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    half = 1'b0; one = 1'b0; buy = 1'b0; cancel = 1'b0; sel = 3'd0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    #2;
    n_chk++; if ({credit0, busy0, drink0, id0, chg_one0, chg_half0, rej0, nak0} !== 14'd0) begin
      n_fail++; $display("FAIL reset_dut0 got=%b exp=0", {credit0, busy0, drink0, id0, chg_one0, chg_half0, rej0, nak0}); end
    n_chk++; if ({credit1, busy1, drink1, id1, chg_one1, chg_half1, rej1, nak1} !== 14'd0) begin
      n_fail++; $display("FAIL reset_auto got=%b exp=0", {credit1, busy1, drink1, id1, chg_one1, chg_half1, rej1, nak1}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_buy_exact();
    do_reset();
    half = 1'b1; step();
    n_chk++; if (credit0 !== 4'd1) begin n_fail++; $display("FAIL exact_half credit=%0d exp=1", credit0); end
    half = 1'b0; one = 1'b1; step();
    n_chk++; if (credit0 !== 4'd3) begin n_fail++; $display("FAIL exact_one1 credit=%0d exp=3", credit0); end
    step();
    n_chk++; if (credit0 !== 4'd5) begin n_fail++; $display("FAIL exact_one2 credit=%0d exp=5", credit0); end
    one = 1'b0; buy = 1'b1; sel = 3'd0; step();
    n_chk++; if ({drink0, id0, credit0, busy0} !== {1'b1, 3'd0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL exact_vend drink=%b id=%0d credit=%0d busy=%b exp 1/0/0/1", drink0, id0, credit0, busy0); end
    idle_in();
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if ({drink0, busy0, chg_one0, chg_half0, credit0} !== 8'd0) begin
        n_fail++; $display("FAIL exact_after%0d drink=%b busy=%b one=%b half=%b credit=%0d exp all 0",
                           i, drink0, busy0, chg_one0, chg_half0, credit0); end
    end
  endtask

  task automatic test_change_half();
    do_reset();
    one = 1'b1; step(); step(); step();
    n_chk++; if (credit0 !== 4'd6) begin n_fail++; $display("FAIL chg_credit credit=%0d exp=6", credit0); end
    one = 1'b0; buy = 1'b1; sel = 3'd0; step();
    n_chk++; if ({drink0, id0, credit0} !== {1'b1, 3'd0, 4'd1}) begin
      n_fail++; $display("FAIL chg_vend drink=%b id=%0d credit=%0d exp 1/0/1", drink0, id0, credit0); end
    idle_in(); step();
    n_chk++; if ({busy0, drink0, chg_half0, chg_one0} !== 4'b1000) begin
      n_fail++; $display("FAIL chg_enter busy/drink/half/one=%b exp=1000", {busy0, drink0, chg_half0, chg_one0}); end
    step();
    n_chk++; if ({chg_half0, chg_one0, credit0} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL chg_half half=%b one=%b credit=%0d exp 1/0/0", chg_half0, chg_one0, credit0); end
    step();
    n_chk++; if ({chg_half0, busy0} !== 2'b00) begin
      n_fail++; $display("FAIL chg_idle half=%b busy=%b exp 0/0", chg_half0, busy0); end
  endtask

  task automatic test_nak_cancel();
    do_reset();
    one = 1'b1; step(); step();
    one = 1'b0; buy = 1'b1; sel = 3'd1; step();
    n_chk++; if ({nak0, credit0, busy0, drink0} !== {1'b1, 4'd4, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL nak_price nak=%b credit=%0d busy=%b drink=%b exp 1/4/0/0", nak0, credit0, busy0, drink0); end
    sel = 3'd5; step();
    n_chk++; if ({nak0, credit0, drink0} !== {1'b1, 4'd4, 1'b0}) begin
      n_fail++; $display("FAIL nak_sel nak=%b credit=%0d drink=%b exp 1/4/0", nak0, credit0, drink0); end
    buy = 1'b0; cancel = 1'b1; step();
    n_chk++; if ({busy0, nak0, chg_one0, credit0} !== {1'b1, 1'b0, 1'b0, 4'd4}) begin
      n_fail++; $display("FAIL cancel_enter busy=%b nak=%b one=%b credit=%0d exp 1/0/0/4", busy0, nak0, chg_one0, credit0); end
    cancel = 1'b0; step();
    n_chk++; if ({chg_one0, chg_half0, credit0} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++; $display("FAIL cancel_one1 one=%b half=%b credit=%0d exp 1/0/2", chg_one0, chg_half0, credit0); end
    buy = 1'b1; sel = 3'd7; step();
    n_chk++; if ({chg_one0, chg_half0, credit0, nak0} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL cancel_one2 one=%b half=%b credit=%0d nak=%b exp 1/0/0/0", chg_one0, chg_half0, credit0, nak0); end
    idle_in(); step();
    n_chk++; if ({chg_one0, busy0} !== 2'b00) begin
      n_fail++; $display("FAIL cancel_idle one=%b busy=%b exp 0/0", chg_one0, busy0); end
  endtask

  task automatic test_overflow();
    int ones;
    int halves;
    int k;
    do_reset();
    one = 1'b1;
    for (int i = 0; i < 7; i++) step();
    n_chk++; if (credit0 !== 4'd14) begin n_fail++; $display("FAIL ovf_fill credit=%0d exp=14", credit0); end
    step();
    n_chk++; if ({rej0, credit0} !== {1'b1, 4'd14}) begin
      n_fail++; $display("FAIL ovf_rej rej=%b credit=%0d exp 1/14", rej0, credit0); end
    one = 1'b0; half = 1'b1; step();
    n_chk++; if ({rej0, credit0} !== {1'b0, 4'd15}) begin
      n_fail++; $display("FAIL ovf_max rej=%b credit=%0d exp 0/15", rej0, credit0); end
    half = 1'b0; cancel = 1'b1; step();
    cancel = 1'b0; half = 1'b1; step();
    n_chk++; if ({rej0, chg_one0, credit0} !== {1'b1, 1'b1, 4'd13}) begin
      n_fail++; $display("FAIL chg_coin_rej rej=%b one=%b credit=%0d exp 1/1/13", rej0, chg_one0, credit0); end
    half = 1'b0;
    ones = 1; halves = 0; k = 0;
    while (busy0 && k < 20) begin
      step();
      ones += int'(chg_one0);
      halves += int'(chg_half0);
      k++;
    end
    n_chk++; if (k >= 20) begin n_fail++; $display("FAIL drain_timeout busy=%b after %0d cycles", busy0, k); end
    n_chk++; if ({ones, halves} !== {32'd7, 32'd1}) begin
      n_fail++; $display("FAIL drain_coins ones=%0d halves=%0d exp 7/1", ones, halves); end
    n_chk++; if (credit0 !== 4'd0) begin n_fail++; $display("FAIL drain_credit credit=%0d exp=0", credit0); end
  endtask

  task automatic test_auto_vend();
    do_reset();
    half = 1'b1; step();
    half = 1'b0; one = 1'b1; step(); step();
    one = 1'b0;
    n_chk++; if ({credit1, drink1} !== {4'd5, 1'b0}) begin
      n_fail++; $display("FAIL auto_collect credit=%0d drink=%b exp 5/0", credit1, drink1); end
    step();
    n_chk++; if ({drink1, id1, credit1, busy1} !== {1'b1, 3'd0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL auto_vend1 drink=%b id=%0d credit=%0d busy=%b exp 1/0/0/1", drink1, id1, credit1, busy1); end
    step();
    n_chk++; if ({drink1, busy1, chg_half1, chg_one1} !== 4'd0) begin
      n_fail++; $display("FAIL auto_idle1 drink/busy/half/one=%b exp 0", {drink1, busy1, chg_half1, chg_one1}); end
    one = 1'b1; step(); step(); step();
    one = 1'b0;
    n_chk++; if (credit1 !== 4'd6) begin n_fail++; $display("FAIL auto_credit6 credit=%0d exp=6", credit1); end
    step();
    n_chk++; if ({drink1, id1, credit1} !== {1'b1, 3'd0, 4'd1}) begin
      n_fail++; $display("FAIL auto_vend2 drink=%b id=%0d credit=%0d exp 1/0/1", drink1, id1, credit1); end
    step(); step();
    n_chk++; if ({chg_half1, chg_one1, credit1} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL auto_half half=%b one=%b credit=%0d exp 1/0/0", chg_half1, chg_one1, credit1); end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    one = 1'b1; step(); step(); step();
    one = 1'b0; cancel = 1'b1; step();
    cancel = 1'b0;
    n_chk++; if ({busy0, credit0} !== {1'b1, 4'd6}) begin
      n_fail++; $display("FAIL rmc_pre busy=%b credit=%0d exp 1/6", busy0, credit0); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({busy0, credit0, chg_one0, chg_half0} !== 7'd0) begin
      n_fail++; $display("FAIL rmc_async busy=%b credit=%0d one=%b half=%b exp 0", busy0, credit0, chg_one0, chg_half0); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if ({chg_one0, chg_half0, busy0, credit0} !== 7'd0) begin
        n_fail++; $display("FAIL rmc_quiet%0d one=%b half=%b busy=%b credit=%0d exp 0",
                           i, chg_one0, chg_half0, busy0, credit0); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    one = 1'b1; step(); step(); step();
    buy = 1'b1; sel = 3'd0; step();
    n_chk++; if ({drink0, rej0, credit0} !== {1'b1, 1'b1, 4'd1}) begin
      n_fail++; $display("FAIL buy_coin drink=%b rej=%b credit=%0d exp 1/1/1", drink0, rej0, credit0); end
    buy = 1'b0; step();
    n_chk++; if ({rej0, busy0, credit0} !== {1'b1, 1'b1, 4'd1}) begin
      n_fail++; $display("FAIL vend_coin rej=%b busy=%b credit=%0d exp 1/1/1", rej0, busy0, credit0); end
    idle_in(); step(); step(); step();
    n_chk++; if ({busy0, credit0} !== {1'b0, 4'd0}) begin
      n_fail++; $display("FAIL b2b_end busy=%b credit=%0d exp 0/0", busy0, credit0); end
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    test_reset();
    test_buy_exact();
    test_change_half();
    test_nak_cancel();
    test_overflow();
    test_auto_vend();
    test_reset_mid_change();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Parametrised vending-machine controller; successor to the single-product, fixed-price coin machine.
- Accepts 0.5-unit and 1-unit coins.
- Sells N_ITEMS products, each at its own price.
- Supports explicit buy, cancel/refund and coin-by-coin change return.
- Optional AUTO_VEND mode reproduces the legacy auto-dispense behaviour for item 0.
- Sits between the coin-acceptor/keypad front end and the dispenser/coin-hopper drivers.

Parameters:
- N_ITEMS, 2, number of products (1..8).
- CREDIT_W, 4, credit register width in half-units (0.5 each).
- PRICES, {4'd6,4'd5}, packed N_ITEMS×CREDIT_W price list in half-units; item i at bits [i*CREDIT_W +: CREDIT_W]. Default: item0 = 2.5, item1 = 3.0.
- AUTO_VEND, 0, 1 = vend item 0 automatically once credit ≥ PRICES[0] with no buy needed.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- half, input, 1, 0.5-unit coin; one coin per cycle sampled high.
- one, input, 1, 1-unit coin; one coin per cycle sampled high.
- buy, input, 1, purchase request, sampled each cycle.
- sel, input, 3, product index for buy.
- cancel, input, 1, refund request.
- credit, output, CREDIT_W, current credit in half-units.
- busy, output, 1, high in VEND or CHANGE.
- drink, output, 1, one-cycle dispense pulse.
- drink_id, output, 3, index of the product dispensed; valid with drink.
- change_one, output, 1, one-cycle pulse: return one 1-unit coin.
- change_half, output, 1, one-cycle pulse: return one 0.5-unit coin.
- coin_rej, output, 1, one-cycle pulse: a coin sampled this cycle was rejected and returned.
- buy_nak, output, 1, one-cycle pulse: buy refused.

Behaviour:
- Reset (async assert): state IDLE; credit = 0; all outputs 0, including drink_id = 0. Reset mid-vend or mid-change aborts the operation; pending change is discarded.
- All outputs are registered. An event sampled at rising edge k is visible after edge k, i.e. in cycle k+1.
- States:
  - IDLE: credit == 0.
  - COLLECT: credit > 0, accepting coins.
  - VEND: single cycle.
  - CHANGE: returning coins.
- Coins, IDLE/COLLECT only:
  - Per cycle, add half(1) + one(2); both high adds 3.
  - If the sum would exceed 2^CREDIT_W − 1, reject the whole sample: coin_rej = 1, credit unchanged.
  - Any coin sampled in VEND or CHANGE is rejected: coin_rej = 1.
- Priority in IDLE/COLLECT: cancel > buy > coin. A coin sampled in the same cycle as an accepted cancel or buy is rejected (coin_rej = 1).
- Cancel:
  - credit > 0: go to CHANGE.
  - credit == 0: ignore.
- Buy:
  - Refused with buy_nak = 1 and no state change if sel ≥ N_ITEMS or credit < PRICES[sel].
  - Otherwise go to VEND and set credit −= PRICES[sel].
- VEND: drink = 1 and drink_id = sel (registered) for exactly one cycle. Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE:
  - One coin per cycle: change_one while credit ≥ 2 (credit −= 2), else change_half (credit −= 1).
  - Return to IDLE on the cycle after credit reaches 0.
  - buy and cancel are ignored; buy_nak is not asserted.
- AUTO_VEND = 1: in COLLECT, if an accepted coin makes credit ≥ PRICES[0], the next edge enters VEND with drink_id = 0. Explicit buy remains available.
- busy = (state == VEND || state == CHANGE).

Decomposition:
- Package vend_pkg:
  - state enum: IDLE, COLLECT, VEND, CHANGE.
  - coin constants: HALF_VAL = 1, ONE_VAL = 2.
  - SEL_W = 3.
- Sub-module vend_change_disp: owns the CHANGE-state coin sequencing.
  - Inputs: start, amount.
  - Outputs: change_one, change_half, done.
- The credit register and FSM stay in vend_ctrl.

Test Plan:
- Defaults. half, one, one on consecutive cycles → credit 1, 3, 5. buy sel=0 → drink = 1, drink_id = 0 one cycle later. credit = 0, no change pulses, back to IDLE.
- Defaults. Three one coins (credit = 6), buy sel=0 (price 5) → drink, then one change_half pulse; credit = 0.
- one ×2 (credit = 4), buy sel=1 → buy_nak = 1, credit stays 4. cancel → change_one, change_one on two consecutive cycles, then IDLE.
- credit = 14, one → coin_rej = 1, credit stays 14. Coin during CHANGE → coin_rej = 1.
- AUTO_VEND = 1. half, one, one → drink with drink_id = 0 without buy, credit 0. Repeat with three one coins → drink, then change_half.
- rst asserted mid-CHANGE with credit = 6 → outputs 0 immediately, credit = 0, no further change pulses; buy + coin in the same cycle → coin_rej = 1.
